// File: rtl/switch_matrix_scanner_pkg.sv
// Shared switch/LED matrix definitions: scan states and cell ordering.
package matrix_pkg;

  localparam int MAX_N = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE
  } scan_state_t;

  function automatic int cell_index(
    input int r,
    input int c,
    input int n
  );
    return r * n + c;
  endfunction

endpackage

// File: rtl/switch_matrix_scanner_sync_2ff.sv
// Two-flop synchronizer, synchronous active-high reset.
module sync_2ff #(
  parameter int           W    = 1,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= INIT;
      q    <= INIT;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/switch_matrix_scanner.sv
// Column-at-a-time N x N switch matrix scanner producing an N*N cell map.
// Optional per-cell debounce: define SWITCH_MATRIX_DEBOUNCE_EN.
module switch_matrix_scanner
  import matrix_pkg::*;
#(
  parameter int N               = 5,
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [N-1:0]         row_sense,
  output logic [N-1:0]         col_drive,
  output logic [$clog2(N):0]   x,
  output logic [N*N-1:0]       cells,
  output logic                 frame_done
);

  localparam int XW = $clog2(N) + 1;
  localparam int CW = $clog2(SETTLE_CYCLES) + 1;

  if (N < 1 || N > MAX_N) begin : g_bad_n
    $error("switch_matrix_scanner: N must be 1..8");
  end
  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("switch_matrix_scanner: SETTLE_CYCLES must be >= 3");
  end
  if (DEBOUNCE_FRAMES < 1) begin : g_bad_deb
    $error("switch_matrix_scanner: DEBOUNCE_FRAMES must be >= 1");
  end

  scan_state_t   state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  synced;
  logic [N-1:0]  raw;
  logic          last;
  logic [XW-1:0] xn;

  // Idle lines are high, so reset the synchronizer to "all open".
  sync_2ff #(
    .W   (N),
    .INIT({N{1'b1}})
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (row_sense),
    .q  (synced)
  );

  assign raw = ~synced;

  always_comb begin
    last = (x == XW'(N - 1));
    xn   = last ? '0 : x + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      x          <= '0;
      col_drive  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          col_drive <= '0;
          if (ena) begin
            state     <= S_DRIVE;
            col_drive <= N'(1) << x;
          end
        end
        S_DRIVE: begin
          if (!ena) begin
            state     <= S_IDLE;
            cnt       <= '0;
            col_drive <= '0;
          end else if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            state <= S_SAMPLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SAMPLE: begin
          x          <= xn;
          frame_done <= last;
          if (ena) begin
            state     <= S_DRIVE;
            col_drive <= N'(1) << xn;
          end else begin
            state     <= S_IDLE;
            col_drive <= '0;
          end
        end
        default: begin
          state     <= S_IDLE;
          col_drive <= '0;
        end
      endcase
    end
  end

`ifdef SWITCH_MATRIX_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_FRAMES) + 1;

  logic [N*N-1:0] cand;
  logic [DW-1:0]  dcnt [N*N];
  logic [DW-1:0]  nxt  [N];
  logic [N-1:0]   cur;
  logic [N-1:0]   cnd;

  always_comb begin
    for (int r = 0; r < N; r++) begin
      cur[r] = cells[cell_index(r, int'(x), N)];
      cnd[r] = cand[cell_index(r, int'(x), N)];
      nxt[r] = (raw[r] == cnd[r])
             ? dcnt[cell_index(r, int'(x), N)] + 1'b1
             : DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cells <= '0;
      cand  <= '0;
      for (int i = 0; i < N * N; i++) dcnt[i] <= '0;
    end else if (state == S_SAMPLE) begin
      for (int r = 0; r < N; r++) begin
        if (raw[r] != cur[r]) begin
          cand[cell_index(r, int'(x), N)] <= raw[r];
          if (nxt[r] >= DW'(DEBOUNCE_FRAMES)) begin
            cells[cell_index(r, int'(x), N)] <= raw[r];
            dcnt[cell_index(r, int'(x), N)]  <= '0;
          end else begin
            dcnt[cell_index(r, int'(x), N)] <= nxt[r];
          end
        end else begin
          dcnt[cell_index(r, int'(x), N)] <= '0;
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      cells <= '0;
    end else if (state == S_SAMPLE) begin
      for (int r = 0; r < N; r++)
        cells[cell_index(r, int'(x), N)] <= raw[r];
    end
  end
`endif

endmodule

// File: tb/tb_switch_matrix_scanner.sv
// Directed bench for switch_matrix_scanner with a behavioural key matrix.
module tb_switch_matrix_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic [4:0]  row_sense;
  logic [4:0]  col_drive;
  logic [3:0]  x;
  logic [24:0] cells;
  logic        frame_done;

  logic [24:0] pressed = '0;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  int zeros;
  int maxx;

  always #5 clk = ~clk;

  // A closed key pulls its row low only while its column is driven.
  always_comb begin
    for (int r = 0; r < 5; r++)
      row_sense[r] = ~|(pressed[r*5 +: 5] & col_drive);
  end

  switch_matrix_scanner dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .row_sense (row_sense),
    .col_drive (col_drive),
    .x         (x),
    .cells     (cells),
    .frame_done(frame_done)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_done !== 1'b1 && n < 200);
    check("fd_seen", 64'(frame_done), 64'd1);
  endtask

  initial begin
    // Reset held with ena high
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_col", 64'(col_drive), 64'd0);
      check("rst_x", 64'(x), 64'd0);
      check("rst_cells", 64'(cells), 64'd0);
      check("rst_fd", 64'(frame_done), 64'd0);
    end

    // Single key at row 2, col 3 -> bit 13
    pressed = 25'd1 << 13;
    rst = 1'b0;
    tick();
    check("walk_col0", 64'(col_drive), 64'h01);
    check("walk_x0", 64'(x), 64'd0);
    for (int k = 1; k < 5; k++) begin
      repeat (17) tick();
      check("walk_col", 64'(col_drive), 64'(5'd1 << k));
      check("walk_x", 64'(x), 64'(k));
    end
    repeat (16) tick();
    check("pre_fd", 64'(frame_done), 64'd0);
    check("pre_fd_col", 64'(col_drive), 64'h10);
    tick();
    check("fd1", 64'(frame_done), 64'd1);
    check("cells_key", 64'(cells), 64'h2000);
    check("wrap_x", 64'(x), 64'd0);
    check("wrap_col", 64'(col_drive), 64'h01);
    tick();
    check("fd_pulse", 64'(frame_done), 64'd0);

    // Free-run two more frames
    zeros = 0;
    maxx = 0;
    for (int f = 0; f < 2; f++) begin
      cyc = (f == 0) ? 1 : 0;
      do begin
        tick();
        cyc++;
        if (col_drive == 5'd0) zeros++;
        if (int'(x) > maxx) maxx = int'(x);
      end while (frame_done !== 1'b1 && cyc < 200);
      check("fd_period", 64'(cyc), 64'd85);
    end
    check("no_zero_drive", 64'(zeros), 64'd0);
    check("max_x", 64'(maxx), 64'd4);
    check("cells_hold", 64'(cells), 64'h2000);

    // ena drop at settle count 7 of column 2
    repeat (41) tick();
    check("c2_drive", 64'(col_drive), 64'h04);
    ena = 1'b0;
    tick();
    check("drop_col", 64'(col_drive), 64'd0);
    check("drop_x", 64'(x), 64'd2);
    repeat (3) tick();
    check("idle_col", 64'(col_drive), 64'd0);
    check("idle_x", 64'(x), 64'd2);
    check("idle_cells", 64'(cells), 64'h2000);
    ena = 1'b1;
    tick();
    check("re_col", 64'(col_drive), 64'h04);
    repeat (16) tick();
    check("re_full", 64'(col_drive), 64'h04);
    check("re_full_x", 64'(x), 64'd2);
    tick();
    check("re_next", 64'(col_drive), 64'h08);
    check("re_next_x", 64'(x), 64'd3);

    // ena drop during sample: sample finishes, then idle
    repeat (16) tick();
    ena = 1'b0;
    tick();
    check("samp_drop_col", 64'(col_drive), 64'd0);
    check("samp_drop_x", 64'(x), 64'd4);
    ena = 1'b1;
    tick();
    check("samp_re_col", 64'(col_drive), 64'h10);

    // Corner keys (0,4) and (4,0)
    pressed = (25'd1 << 4) | (25'd1 << 20);
    wait_fd(cyc);
    wait_fd(cyc);
    check("cells_corner", 64'(cells), 64'h100010);

    // All keys, then reset mid-frame
    pressed = '1;
    wait_fd(cyc);
    wait_fd(cyc);
    check("cells_all", 64'(cells), 64'h1FFFFFF);
    repeat (40) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_cells", 64'(cells), 64'd0);
    check("mid_rst_x", 64'(x), 64'd0);
    check("mid_rst_col", 64'(col_drive), 64'd0);
    check("mid_rst_fd", 64'(frame_done), 64'd0);
    rst = 1'b0;
    tick();
    check("restart_col", 64'(col_drive), 64'h01);
    check("restart_x", 64'(x), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
